// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge port between the IF stage (master) and memory (slave).
interface instruction_fetch_unit_if;
  logic        IMem_Req;
  logic [31:0] IMem_Addr;
  logic        IMem_Ack;
  logic [31:0] IMem_RData;

  modport master (output IMem_Req, IMem_Addr, input IMem_Ack, IMem_RData);
  modport slave  (input IMem_Req, IMem_Addr, output IMem_Ack, IMem_RData);
endinterface

// File: rtl/instruction_fetch_unit.sv
// IF stage of the delay-slot MIPS pipeline: PC, req/ack fetch, IF/ID register and
// a one-word buffer that carries a fetched instruction across ID stalls.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hBFC00000,
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      Stall,
  input  logic                      Redirect,
  input  logic [31:0]               Redirect_PC,
  instruction_fetch_unit_if.master  imem,
  output logic                      IFID_Valid,
  output logic [31:0]               IFID_Instruction,
  output logic [31:0]               IFID_PC_Plus4
);
  typedef enum logic {FETCH, HELD} state_t;

  state_t      state_q, state_d;
  logic        active_q, active_d;
  logic [31:0] pc_q, pc_d;
  logic        pending_q, pending_d;
  logic [31:0] pending_pc_q, pending_pc_d;
  logic [31:0] buf_q, buf_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;

  logic        req, ack, accept, redir;
  logic [31:0] pc_plus4, redir_tgt;

  // active_q keeps Req low for the first edge after reset and masks stray acks.
  assign req       = active_q && (state_q == FETCH);
  assign ack       = req && imem.IMem_Ack;
  assign redir     = Redirect && !Stall;
  assign redir_tgt = Redirect_PC & 32'hFFFF_FFFC;
  assign pc_plus4  = pc_q + 32'd4;
  assign accept    = !Stall && (ack || state_q == HELD);

  always_comb begin
    state_d      = state_q;
    active_d     = 1'b1;
    pc_d         = pc_q;
    pending_d    = pending_q;
    pending_pc_d = pending_pc_q;
    buf_d        = buf_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    if (accept) begin
      valid_d   = 1'b1;
      instr_d   = (state_q == HELD) ? buf_q : imem.IMem_RData;
      pc4_d     = pc_plus4;
      state_d   = FETCH;
      pending_d = 1'b0;
      // The accepted word is the delay slot of any outstanding redirect.
      if (pending_q)  pc_d = pending_pc_q;
      else if (redir) pc_d = redir_tgt;
      else            pc_d = pc_plus4;
    end else if (!Stall) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      if (redir) begin
        pending_d    = 1'b1;
        pending_pc_d = redir_tgt;
      end
    end else if (ack) begin
      buf_d   = imem.IMem_RData;
      state_d = HELD;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= FETCH;
      active_q     <= 1'b0;
      pc_q         <= RESET_PC;
      pending_q    <= 1'b0;
      pending_pc_q <= 32'h0;
      buf_q        <= NOP_INSTR;
      valid_q      <= 1'b0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      pending_pc_q <= pending_pc_d;
      buf_q        <= buf_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
    end
  end

  assign imem.IMem_Req  = req;
  assign imem.IMem_Addr = pc_q;
  assign IFID_Valid       = valid_q;
  assign IFID_Instruction = instr_q;
  assign IFID_PC_Plus4    = pc4_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: reset, streaming, stall buffering,
// delay-slot redirects, pending redirects and PC wraparound.
module tb_instruction_fetch_unit;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        Stall = 1'b0;
  logic        Redirect = 1'b0;
  logic [31:0] Redirect_PC = 32'h0;
  logic        IFID_Valid;
  logic [31:0] IFID_Instruction, IFID_PC_Plus4;
  int          vectors = 0;
  int          miscompares = 0;

  instruction_fetch_unit_if imem ();

  instruction_fetch_unit dut (
    .CLK(CLK), .RESET(RESET), .Stall(Stall), .Redirect(Redirect),
    .Redirect_PC(Redirect_PC), .imem(imem), .IFID_Valid(IFID_Valid),
    .IFID_Instruction(IFID_Instruction), .IFID_PC_Plus4(IFID_PC_Plus4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic ifid(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] p4);
    chk({tag, ".valid"}, {31'b0, IFID_Valid}, {31'b0, v});
    chk({tag, ".instr"}, IFID_Instruction, ins);
    chk({tag, ".pc4"},   IFID_PC_Plus4, p4);
  endtask

  task automatic mem(input logic a, input logic [31:0] d);
    imem.IMem_Ack   = a;
    imem.IMem_RData = d;
  endtask

  initial begin
    mem(1'b0, 32'h0);
    // T1: reset state, then reset asserted mid-fetch with an ack present
    #3;
    chk("rst.req", {31'b0, imem.IMem_Req}, 32'd0);
    ifid("rst", 1'b0, 32'h0, 32'h0);
    #9 RESET = 1'b0;
    #1 chk("rel.req", {31'b0, imem.IMem_Req}, 32'd0);
    step();
    chk("t1.req", {31'b0, imem.IMem_Req}, 32'd1);
    chk("t1.addr", imem.IMem_Addr, 32'hBFC00000);
    mem(1'b1, 32'hDEAD0001);
    #2 RESET = 1'b1;
    #1 chk("t1.async.req", {31'b0, imem.IMem_Req}, 32'd0);
    chk("t1.async.valid", {31'b0, IFID_Valid}, 32'd0);
    step();
    ifid("t1.ackign", 1'b0, 32'h0, 32'h0);
    RESET = 1'b0;
    mem(1'b0, 32'h0);
    step();
    chk("t1.rel.req", {31'b0, imem.IMem_Req}, 32'd1);
    chk("t1.rel.addr", imem.IMem_Addr, 32'hBFC00000);
    ifid("t1.rel", 1'b0, 32'h0, 32'h0);

    // T2: zero-wait memory, one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      mem(1'b1, 32'h10000000 + i);
      step();
      ifid("t2", 1'b1, 32'h10000000 + i, 32'hBFC00004 + 4 * i);
    end
    chk("t2.addr", imem.IMem_Addr, 32'hBFC00010);

    // T3: ack under stall is buffered; IF/ID holds for 3 stalled cycles
    Stall = 1'b1;
    mem(1'b1, 32'hAAAA0001);
    step();
    mem(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("t3.req", {31'b0, imem.IMem_Req}, 32'd0);
      ifid("t3.hold", 1'b1, 32'h10000003, 32'hBFC00010);
      if (i < 2) step();
    end
    Stall = 1'b0;
    step();
    ifid("t3.acc", 1'b1, 32'hAAAA0001, 32'hBFC00014);
    chk("t3.addr", imem.IMem_Addr, 32'hBFC00014);
    chk("t3.req1", {31'b0, imem.IMem_Req}, 32'd1);

    // Move to 0x00400000 via a redirect, then stream to 0x00400008
    Redirect = 1'b1; Redirect_PC = 32'h00400000;
    mem(1'b1, 32'h20000000);
    step();
    ifid("mv.ds", 1'b1, 32'h20000000, 32'hBFC00018);
    chk("mv.addr", imem.IMem_Addr, 32'h00400000);
    Redirect = 1'b0;
    mem(1'b1, 32'h20000001);
    step();
    mem(1'b1, 32'h20000002);
    step();
    chk("mv.addr2", imem.IMem_Addr, 32'h00400008);

    // T4: delay slot delivered, target low bits ignored
    Redirect = 1'b1; Redirect_PC = 32'h00400103;
    mem(1'b1, 32'h30000000);
    step();
    ifid("t4.ds", 1'b1, 32'h30000000, 32'h0040000C);
    chk("t4.addr", imem.IMem_Addr, 32'h00400100);

    // T5: redirect during wait states -> pending, last redirect wins
    Redirect_PC = 32'h00800000;
    mem(1'b0, 32'h0);
    step();
    ifid("t5.bub1", 1'b0, 32'h0, 32'h0040000C);
    chk("t5.addr1", imem.IMem_Addr, 32'h00400100);
    Redirect_PC = 32'h00900000;
    step();
    ifid("t5.bub2", 1'b0, 32'h0, 32'h0040000C);
    Redirect = 1'b0;
    mem(1'b1, 32'h40000000);
    step();
    ifid("t5.ds", 1'b1, 32'h40000000, 32'h00400104);
    chk("t5.addr", imem.IMem_Addr, 32'h00900000);

    // T6: PC wraparound from 0xFFFFFFFC
    Redirect = 1'b1; Redirect_PC = 32'hFFFFFFFC;
    mem(1'b1, 32'h50000000);
    step();
    chk("t6.addr0", imem.IMem_Addr, 32'hFFFFFFFC);
    Redirect = 1'b0;
    mem(1'b1, 32'h50000001);
    step();
    ifid("t6.wrap", 1'b1, 32'h50000001, 32'h00000000);
    chk("t6.addr", imem.IMem_Addr, 32'h00000000);

    // Redirect while stalled is ignored
    Stall = 1'b1; Redirect = 1'b1; Redirect_PC = 32'h12345678;
    mem(1'b0, 32'h0);
    step();
    ifid("stl.hold", 1'b1, 32'h50000001, 32'h00000000);
    Stall = 1'b0; Redirect = 1'b0;
    mem(1'b1, 32'h60000000);
    step();
    ifid("stl.acc", 1'b1, 32'h60000000, 32'h00000004);
    chk("stl.addr", imem.IMem_Addr, 32'h00000004);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
